// File: rtl/seg7_scan_decode.sv
// Purpose: decode a multiplexed active-low 7-segment bus back into a frame of hex nibbles.
// Latency: a digit held from edge t is captured at edge t+2+STABLE; a completing capture raises VALID one edge later.
// Backpressure: VALID holds the frame until READY; scanning continues into the slots meanwhile.
module seg7_scan_decode #(
   parameter int NDIG   = 4,
   parameter int STABLE = 16
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic [7:0]        nSEG,
   input  logic [NDIG-1:0]   nDIG,
   output logic [4*NDIG-1:0] DOUT,
   output logic [NDIG-1:0]   DP,
   output logic [NDIG-1:0]   ERR,
   output logic              VALID,
   input  logic              READY
);
   localparam int W  = 8 + NDIG;
   localparam int KW = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

   logic [W-1:0]             s1_q, s2_q, s3_q;
   logic [7:0]               cnt_q, cnt_d;
   logic [7:0]               seg_s;
   logic [NDIG-1:0]          dig_s, dig_low;
   logic                     one_low, cap;
   logic [KW-1:0]            k;
   logic [4:0]               dec;
   logic [NDIG-1:0]          cap_mask;
   logic [NDIG-1:0][3:0]     nib_q;
   logic [NDIG-1:0]          dp_slot_q, err_slot_q;
   logic [NDIG-1:0]          seen_q, seen_d;
   logic                     full, load;
   state_t                   state_q;
   logic [4*NDIG-1:0]        dout_q;
   logic [NDIG-1:0]          dp_q, err_q;
   logic                     valid_q;

   // Legal codes map to their hex value; anything else flags an error with nibble 0.
   function automatic logic [4:0] decode7(input logic [6:0] seg);
      case (seg)
         7'h40: return 5'h00;
         7'h79: return 5'h01;
         7'h24: return 5'h02;
         7'h30: return 5'h03;
         7'h19: return 5'h04;
         7'h12: return 5'h05;
         7'h02: return 5'h06;
         7'h58: return 5'h07;
         7'h00: return 5'h08;
         7'h10: return 5'h09;
         7'h08: return 5'h0A;
         7'h03: return 5'h0B;
         7'h27: return 5'h0C;
         7'h21: return 5'h0D;
         7'h06: return 5'h0E;
         7'h0E: return 5'h0F;
         default: return 5'h10;
      endcase
   endfunction

   assign seg_s   = s2_q[W-1:NDIG];
   assign dig_s   = s2_q[NDIG-1:0];
   assign dig_low = ~dig_s;

   // Stability counter restarts on any change of the synchronised pair and saturates at STABLE.
   always_comb begin
      cnt_d = cnt_q;
      if (s2_q != s3_q) begin
         cnt_d = 8'd0;
      end else if (cnt_q != 8'(STABLE)) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Two-flop synchroniser plus a history stage used for change detection.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         s1_q  <= '1;
         s2_q  <= '1;
         s3_q  <= '1;
         cnt_q <= 8'd0;
      end else begin
         s1_q  <= {nSEG, nDIG};
         s2_q  <= s1_q;
         s3_q  <= s2_q;
         cnt_q <= cnt_d;
      end
   end

   // Locate the single low strobe and decide whether this edge captures.
   always_comb begin
      k       = '0;
      one_low = (dig_low != '0) && ((dig_low & (dig_low - NDIG'(1))) == '0);
      for (int i = 0; i < NDIG; i++) begin
         if (dig_low[i]) k = KW'(i);
      end
      cap      = (s2_q == s3_q) && (cnt_q == 8'(STABLE - 1)) && one_low;
      cap_mask = cap ? (NDIG'(1) << k) : '0;
      dec      = decode7(seg_s[6:0]);
   end

   // A frame loads when all slots are seen and the output register is free or being accepted;
   // a capture on the load edge starts the next frame.
   always_comb begin
      full   = &seen_q;
      load   = full && ((state_q == COLLECT) || READY);
      seen_d = load ? cap_mask : (seen_q | cap_mask);
   end

   // Per-digit slots, overwritten by each newer capture of the same position.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         nib_q      <= '0;
         dp_slot_q  <= '0;
         err_slot_q <= '0;
         seen_q     <= '0;
      end else begin
         if (cap) begin
            nib_q[k]      <= dec[3:0];
            err_slot_q[k] <= dec[4];
            dp_slot_q[k]  <= ~seg_s[7];
         end
         seen_q <= seen_d;
      end
   end

   // Output control: COLLECT waits for a full frame, HOLD freezes it until accepted.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= COLLECT;
         dout_q  <= '0;
         dp_q    <= '0;
         err_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            COLLECT: begin
               if (full) begin
                  dout_q  <= nib_q;
                  dp_q    <= dp_slot_q;
                  err_q   <= err_slot_q;
                  valid_q <= 1'b1;
                  state_q <= HOLD;
               end
            end
            HOLD: begin
               if (READY) begin
                  if (full) begin
                     dout_q  <= nib_q;
                     dp_q    <= dp_slot_q;
                     err_q   <= err_slot_q;
                  end else begin
                     valid_q <= 1'b0;
                     state_q <= COLLECT;
                  end
               end
            end
            default: state_q <= COLLECT;
         endcase
      end
   end

   assign DOUT  = dout_q;
   assign DP    = dp_q;
   assign ERR   = err_q;
   assign VALID = valid_q;

endmodule

// File: tb/tb_seg7_scan_decode.sv
// Bench for seg7_scan_decode: directed scans from the test plan plus random scanning,
// every cycle compared against a history-based model of capture and frame delivery.
module tb_seg7_scan_decode;
   localparam int NDIG   = 4;
   localparam int STABLE = 4;
   localparam int W      = 8 + NDIG;

   logic              CLK = 1'b0;
   logic              nRST;
   logic [7:0]        nSEG;
   logic [NDIG-1:0]   nDIG;
   logic [4*NDIG-1:0] DOUT;
   logic [NDIG-1:0]   DP, ERR;
   logic              VALID;
   logic              READY;

   int n_tot  = 0;
   int n_pass = 0;

   logic [6:0] codes [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h58,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};

   seg7_scan_decode #(.NDIG(NDIG), .STABLE(STABLE)) dut (
      .CLK(CLK), .nRST(nRST), .nSEG(nSEG), .nDIG(nDIG),
      .DOUT(DOUT), .DP(DP), .ERR(ERR), .VALID(VALID), .READY(READY)
   );

   always #5 CLK = ~CLK;

   // ---------------- reference model ----------------
   // hist[i] is the input pair sampled i+1 edges ago.
   logic [W-1:0]      hist [0:STABLE+2];
   int                m_nib [0:NDIG-1];
   bit [NDIG-1:0]     m_dps, m_errs, m_seen;
   bit                m_valid;
   logic [4*NDIG-1:0] m_dout;
   bit [NDIG-1:0]     m_dp, m_err;

   task automatic model_reset();
      for (int i = 0; i <= STABLE + 2; i++) hist[i] = '1;
      for (int i = 0; i < NDIG; i++) m_nib[i] = 0;
      m_dps = '0; m_errs = '0; m_seen = '0; m_valid = 0;
      m_dout = '0; m_dp = '0; m_err = '0;
   endtask

   task automatic model_step();
      bit            eq, cap, full;
      int            k, zeros, nib;
      bit            bad;
      logic [7:0]    s;
      logic [NDIG-1:0] d;
      // a pair that entered the synchroniser STABLE+1 samples ago, unchanged since, and
      // different from what preceded it, is captured on this edge
      eq = 1;
      for (int i = 2; i <= STABLE + 1; i++) if (hist[i] != hist[1]) eq = 0;
      cap = 0; k = 0;
      if (eq && hist[STABLE+2] != hist[1]) begin
         d = hist[1][NDIG-1:0];
         zeros = 0;
         for (int i = 0; i < NDIG; i++) if (!d[i]) begin zeros++; k = i; end
         cap = (zeros == 1);
      end
      full = 1;
      for (int i = 0; i < NDIG; i++) if (!m_seen[i]) full = 0;
      if (!m_valid || READY) begin
         if (full) begin
            for (int i = 0; i < NDIG; i++) m_dout[4*i +: 4] = 4'(m_nib[i]);
            m_dp = m_dps; m_err = m_errs; m_valid = 1; m_seen = '0;
         end else begin
            m_valid = 0;
         end
      end
      if (cap) begin
         s = hist[1][W-1:NDIG];
         nib = 0; bad = 1;
         for (int j = 0; j < 16; j++) if (s[6:0] == codes[j]) begin nib = j; bad = 0; end
         m_nib[k] = nib; m_errs[k] = bad; m_dps[k] = ~s[7]; m_seen[k] = 1;
      end
      for (int i = STABLE + 2; i >= 1; i--) hist[i] = hist[i-1];
      hist[0] = {nSEG, nDIG};
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge CLK or negedge nRST);
         if (!nRST) model_reset();
         else model_step();
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   initial begin
      forever begin
         @(posedge CLK);
         #1;
         chk("cycle {VALID,ERR,DP,DOUT}", 32'({VALID, ERR, DP, DOUT}),
             32'({m_valid, m_err, m_dp, m_dout}));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic put(input logic [7:0] s, input logic [NDIG-1:0] d, input int n);
      nSEG = s; nDIG = d;
      repeat (n) @(negedge CLK);
   endtask

   // returns at a negedge; n = edges counted from the call until VALID was seen
   task automatic wait_valid(input string nm, input int lim, output int n);
      n = 0;
      do begin
         @(posedge CLK); #1; n++;
      end while (!VALID && n < lim);
      if (!VALID) begin
         n_tot++;
         $display("FAIL %s: VALID not seen within %0d cycles", nm, lim);
      end
      @(negedge CLK);
   endtask

   task automatic accept();
      READY = 1'b1;
      @(negedge CLK);
      READY = 1'b0;
   endtask

   int n;

   initial begin
      nRST = 1'b0; READY = 1'b0; nSEG = '1; nDIG = '1;
      repeat (3) @(negedge CLK);
      chk("reset outputs", 32'({VALID, ERR, DP, DOUT}), 32'h0);
      nRST = 1'b1;
      put(8'hFF, 4'b1111, 4);

      // basic scan 0..3; VALID follows after edge t+3+STABLE, i.e. the (STABLE+4)th edge
      put(8'hC0, 4'b1110, 10);
      put(8'hF9, 4'b1101, 10);
      put(8'hA4, 4'b1011, 10);
      nSEG = 8'hB0; nDIG = 4'b0111;
      wait_valid("scan latency", 30, n);
      chk("valid latency", 32'(n), 32'(STABLE + 4));
      chk("frame 3210 DOUT", 32'(DOUT), 32'h3210);
      chk("frame 3210 DP/ERR", 32'({DP, ERR}), 32'h0);
      repeat (4) @(negedge CLK);
      accept();
      put(8'hFF, 4'b1111, 6);

      // dp, F and blank digit
      put(8'h40, 4'b1110, 10);
      put(8'hF9, 4'b1101, 10);
      put(8'hFF, 4'b1011, 10);
      nSEG = 8'h8E; nDIG = 4'b0111;
      wait_valid("dp/err frame", 30, n);
      chk("dp/err DOUT", 32'(DOUT), 32'hF010);
      chk("dp/err DP", 32'(DP), 32'h1);
      chk("dp/err ERR", 32'(ERR), 32'h4);
      accept();
      put(8'hFF, 4'b1111, 6);

      // short glitch and multi-low strobe must not capture
      put(8'hC0, 4'b1110, 3);
      put(8'hC0, 4'b1100, 20);
      put(8'hF9, 4'b1101, 10);
      put(8'hA4, 4'b1011, 10);
      put(8'hB0, 4'b0111, 10);
      chk("glitch no valid", 32'(VALID), 32'h0);
      nSEG = 8'hA4; nDIG = 4'b1110;
      wait_valid("post-glitch frame", 30, n);
      chk("post-glitch DOUT", 32'(DOUT), 32'h3212);
      accept();
      put(8'hFF, 4'b1111, 6);

      // two frames while stalled, then back-to-back accept
      put(8'h99, 4'b1110, 10);
      put(8'h92, 4'b1101, 10);
      put(8'h82, 4'b1011, 10);
      put(8'hD8, 4'b0111, 10);
      put(8'h80, 4'b1110, 10);
      put(8'h90, 4'b1101, 10);
      put(8'h88, 4'b1011, 10);
      put(8'h83, 4'b0111, 10);
      chk("stall frame1 held", 32'({VALID, DOUT}), 32'h1_7654);
      READY = 1'b1;
      @(posedge CLK); #1;
      chk("back-to-back frame2", 32'({VALID, DOUT}), 32'h1_BA98);
      @(negedge CLK);
      @(negedge CLK);
      READY = 1'b0;
      chk("drained", 32'(VALID), 32'h0);
      put(8'hFF, 4'b1111, 6);

      // reset after a partial frame
      put(8'hC0, 4'b1110, 10);
      put(8'hF9, 4'b1101, 10);
      nSEG = 8'hFF; nDIG = 4'b1111;
      nRST = 1'b0;
      #1;
      chk("async reset outputs", 32'({VALID, ERR, DP, DOUT}), 32'h0);
      repeat (2) @(negedge CLK);
      nRST = 1'b1;
      put(8'hA4, 4'b1011, 10);
      put(8'hB0, 4'b0111, 10);
      chk("partial discarded", 32'(VALID), 32'h0);
      put(8'h99, 4'b1110, 10);
      nSEG = 8'h92; nDIG = 4'b1101;
      wait_valid("post-reset frame", 30, n);
      chk("post-reset DOUT", 32'(DOUT), 32'h3254);
      accept();
      put(8'hFF, 4'b1111, 6);

      // random scanning with random backpressure
      for (int it = 0; it < 300; it++) begin
         int kind, dwell, kk;
         bit dpb;
         kind  = $urandom_range(0, 9);
         dwell = $urandom_range(1, 12);
         kk    = $urandom_range(0, NDIG - 1);
         dpb   = 1'($urandom_range(0, 1));
         if (kind <= 6) begin
            nSEG = {dpb, codes[$urandom_range(0, 15)]};
            nDIG = ~(NDIG'(1) << kk);
         end else if (kind == 7) begin
            nSEG = 8'($urandom);
            nDIG = ~(NDIG'(1) << kk);
         end else if (kind == 8) begin
            nSEG = {dpb, codes[$urandom_range(0, 15)]};
            nDIG = NDIG'($urandom);
         end else begin
            nDIG = '1;
         end
         if (it == 150) begin
            nRST = 1'b0;
            repeat (2) @(negedge CLK);
            nRST = 1'b1;
         end
         for (int c = 0; c < dwell; c++) begin
            READY = ($urandom_range(0, 3) != 0);
            @(negedge CLK);
         end
      end
      READY = 1'b0;
      repeat (4) @(negedge CLK);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
